// File: rtl/nes_pad_serial_reader.sv
// ============================================================================
// nes_pad_serial_reader: polls an NES pad (CD4021) and presents its buttons.
// Rev 1.0
// ============================================================================
`default_nettype none

module nes_pad_serial_reader #(
  parameter int HALF_CYC  = 300,
  parameter int LATCH_CYC = 600,
  parameter int POLL_CYC  = 833333
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_now,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PHASE_W   = $clog2(PHASE_MAX);
  localparam int POLL_W    = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYC - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYC - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [PHASE_W-1:0]  phase_cnt, phase_nxt;
  logic [2:0]          bit_idx, idx_nxt;
  logic [7:0]          shift_q, shift_nxt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [1:0]          sync_q;
  logic                bit_in;
  logic                poll_start;
  logic [7:0]          remap;

  // Pad drives low for pressed; invert so a pressed button samples as 1.
  assign bit_in = ~sync_q[1];

  // Pad serial order is A,B,Sel,Start,Up,Down,Left,Right; core swaps Up/Down and Left/Right.
  assign remap = {shift_q[6], shift_q[7], shift_q[4], shift_q[5], shift_q[3:0]};

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase_cnt + 1'b1;
    idx_nxt    = bit_idx;
    shift_nxt  = shift_q;
    poll_start = 1'b0;

    case (state)
      IDLE: begin
        phase_nxt = '0;
        if (poll_now || (poll_cnt == POLL_LAST)) begin
          poll_start = 1'b1;
          state_nxt  = LATCH;
        end
      end
      LATCH: begin
        if (phase_cnt == LATCH_LAST) begin
          phase_nxt = '0;
          idx_nxt   = 3'd0;
          state_nxt = BIT_LO;
        end
      end
      BIT_LO: begin
        if (phase_cnt == HALF_LAST) begin
          phase_nxt          = '0;
          shift_nxt[bit_idx] = bit_in;
          state_nxt          = (bit_idx == 3'd7) ? DONE : BIT_HI;
        end
      end
      BIT_HI: begin
        if (phase_cnt == HALF_LAST) begin
          phase_nxt = '0;
          idx_nxt   = bit_idx + 3'd1;
          state_nxt = BIT_LO;
        end
      end
      DONE: begin
        phase_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        phase_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      poll_cnt  <= '0;
      sync_q    <= 2'b11;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      bit_idx   <= idx_nxt;
      shift_q   <= shift_nxt;
      sync_q    <= {sync_q[0], pad_data};

      if (poll_start) begin
        poll_cnt <= '0;
      end else if (poll_cnt != POLL_LAST) begin
        poll_cnt <= poll_cnt + 1'b1;
      end

      // Outputs are registered from the next state so they align with it.
      pad_latch <= (state_nxt == LATCH);
      pad_clk   <= (state_nxt == BIT_HI);
      valid     <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);

      if (state == DONE) begin
        buttons <= remap;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_serial_reader.sv
// ============================================================================
// tb_nes_pad_serial_reader: CD4021 pad model with randomized button patterns.
// ============================================================================
`default_nettype none

module tb_nes_pad_serial_reader;

  localparam int HALF_CYC  = 4;
  localparam int LATCH_CYC = 8;
  localparam int POLL_CYC  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_now = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] buttons;

  nes_pad_serial_reader #(
    .HALF_CYC (HALF_CYC),
    .LATCH_CYC(LATCH_CYC),
    .POLL_CYC (POLL_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .poll_now (poll_now),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latch is high, shift on pad_clk rising edge.
  logic [7:0] pad_btn = 8'h00;
  logic [7:0] pad_sr  = 8'hFF;
  logic       pclk_q  = 1'b0;
  int         ser2core [8] = '{0, 1, 2, 3, 5, 4, 7, 6};

  assign pad_data = pad_sr[7];

  function automatic logic [7:0] pad_image(input logic [7:0] core);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = ~core[ser2core[i]];
    return s;
  endfunction

  always @(posedge clk) begin
    pclk_q <= pad_clk;
    if (pad_latch) pad_sr <= pad_image(pad_btn);
    else if (pad_clk && !pclk_q) pad_sr <= {pad_sr[6:0], 1'b1};
  end

  int   tests = 0, fails = 0;
  int   cyc, rises, latch_hi, latch_rises, valids, overlap = 0;
  logic prev_clk = 1'b0, prev_latch = 1'b0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pad_clk && !prev_clk) rises++;
    if (pad_latch && !prev_latch) latch_rises++;
    if (pad_latch) latch_hi++;
    if (valid) valids++;
    if (pad_latch && pad_clk) overlap++;
    prev_clk   = pad_clk;
    prev_latch = pad_latch;
  endtask

  task automatic clear_counts();
    cyc = 0; rises = 0; latch_hi = 0; latch_rises = 0; valids = 0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
  endtask

  task automatic test_reset();
    int t_latch, t_valid, idle_bad;
    bit ok;
    rst = 1'b1;
    repeat (4) tick();
    tests++;
    if ({pad_latch, pad_clk, valid, busy, buttons} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 000", {pad_latch, pad_clk, valid, busy, buttons});
    end
    pad_btn = 8'hA5;
    rst = 1'b0;
    clear_counts();
    t_latch = -1;
    idle_bad = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (pad_latch) begin
        t_latch = i;
        break;
      end
      if (busy || valid || pad_clk || (buttons != 8'h00)) idle_bad++;
    end
    tests++;
    if (idle_bad !== 0) begin
      fails++;
      $display("FAIL idle_quiet: got %0d bad cycles required 0", idle_bad);
    end
    tests++;
    if (t_latch !== POLL_CYC) begin
      fails++;
      $display("FAIL first_auto_poll: got %0d cycles required %0d", t_latch, POLL_CYC);
    end
    wait_valid(150, ok);
    t_valid = cyc;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL first_valid: got timeout required valid pulse");
    end
    tests++;
    if (t_valid - t_latch + 1 !== LATCH_CYC + 15 * HALF_CYC + 1) begin
      fails++;
      $display("FAIL poll_length: got %0d required %0d", t_valid - t_latch + 1, LATCH_CYC + 15 * HALF_CYC + 1);
    end
    tests++;
    if (buttons !== 8'h00) begin
      fails++;
      $display("FAIL hold_on_done: got %h required 00", buttons);
    end
    tick();
    tests++;
    if (buttons !== 8'hA5) begin
      fails++;
      $display("FAIL first_vector: got %h required a5", buttons);
    end
    tests++;
    if ({rises[7:0], latch_hi[7:0], valids[7:0]} !== {8'd7, 8'd8, 8'd1}) begin
      fails++;
      $display("FAIL first_pulses: got clk=%0d latch=%0d valid=%0d required 7 8 1", rises, latch_hi, valids);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] vecs [12];
    logic [7:0] prev;
    bit ok;
    vecs[0] = 8'h01; vecs[1] = 8'h20; vecs[2] = 8'h88;
    vecs[3] = 8'h52; vecs[4] = 8'hFF; vecs[5] = 8'h00;
    for (int i = 6; i < 12; i++) vecs[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) tick();
      pad_btn = vecs[i];
      prev = buttons;
      clear_counts();
      pulse_poll();
      tests++;
      if (pad_latch !== 1'b1) begin
        fails++;
        $display("FAIL latch_on_poll_now[%0d]: got %b required 1", i, pad_latch);
      end
      wait_valid(120, ok);
      tests++;
      if (!ok || buttons !== prev) begin
        fails++;
        $display("FAIL valid_hold[%0d]: got valid=%b buttons=%h required 1 %h", i, ok, buttons, prev);
      end
      tick();
      tests++;
      if (buttons !== vecs[i]) begin
        fails++;
        $display("FAIL vector[%0d]: got %h required %h", i, buttons, vecs[i]);
      end
      tests++;
      if ({rises[7:0], latch_hi[7:0], valids[7:0], busy} !== {8'd7, 8'd8, 8'd1, 1'b0}) begin
        fails++;
        $display("FAIL pulses[%0d]: got clk=%0d latch=%0d valid=%0d busy=%b required 7 8 1 0", i, rises, latch_hi, valids, busy);
      end
    end
  endtask

  task automatic test_poll_now_counter();
    int t0, t1, t2;
    logic [7:0] v;
    bit ok;
    clear_counts();
    pad_btn = 8'($urandom);
    pulse_poll();
    t0 = cyc;
    wait_valid(120, ok);
    tick();
    for (int i = 0; i < 100 && cyc < t0 + 50; i++) tick();
    v = 8'($urandom);
    pad_btn = v;
    pulse_poll();
    t1 = cyc;
    tests++;
    if (pad_latch !== 1'b1) begin
      fails++;
      $display("FAIL poll_now_at_50: got latch=%b required 1", pad_latch);
    end
    wait_valid(120, ok);
    tick();
    tests++;
    if (!ok || buttons !== v) begin
      fails++;
      $display("FAIL poll_now_vector: got valid=%b buttons=%h required 1 %h", ok, buttons, v);
    end
    latch_rises = 0;
    t2 = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (latch_rises != 0) begin
        t2 = cyc;
        break;
      end
    end
    tests++;
    if (t2 - t1 !== POLL_CYC) begin
      fails++;
      $display("FAIL auto_after_poll_now: got %0d cycles required %0d", t2 - t1, POLL_CYC);
    end
    wait_valid(120, ok);
    tick();
    tests++;
    if (!ok || buttons !== v) begin
      fails++;
      $display("FAIL auto_vector: got valid=%b buttons=%h required 1 %h", ok, buttons, v);
    end
  endtask

  task automatic test_poll_during_bit_hi();
    logic [7:0] v;
    bit ok;
    v = 8'($urandom) | 8'h01;
    pad_btn = v;
    clear_counts();
    pulse_poll();
    for (int i = 0; i < 40 && !pad_clk; i++) tick();
    pulse_poll();
    wait_valid(120, ok);
    tick();
    tests++;
    if (!ok || buttons !== v) begin
      fails++;
      $display("FAIL bit_hi_vector: got valid=%b buttons=%h required 1 %h", ok, buttons, v);
    end
    repeat (30) tick();
    tests++;
    if ({latch_rises[7:0], valids[7:0]} !== {8'd1, 8'd1}) begin
      fails++;
      $display("FAIL bit_hi_ignored: got latch=%0d valid=%0d required 1 1", latch_rises, valids);
    end
  endtask

  task automatic test_reset_mid_poll();
    logic [7:0] v;
    bit ok;
    pad_btn = 8'($urandom);
    clear_counts();
    pulse_poll();
    for (int i = 0; i < 80 && !(rises == 3 && !pad_clk); i++) tick();
    tests++;
    if (rises !== 3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reach_bit3: got clk=%0d busy=%b required 3 1", rises, busy);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({pad_latch, pad_clk, valid, busy, buttons} !== 12'h000) begin
      fails++;
      $display("FAIL mid_poll_reset: got %h required 000", {pad_latch, pad_clk, valid, busy, buttons});
    end
    tick();
    rst = 1'b0;
    v = 8'($urandom);
    pad_btn = v;
    clear_counts();
    tick();
    pulse_poll();
    wait_valid(120, ok);
    tick();
    tests++;
    if (!ok || buttons !== v) begin
      fails++;
      $display("FAIL after_reset_vector: got valid=%b buttons=%h required 1 %h", ok, buttons, v);
    end
    tests++;
    if ({rises[7:0], latch_hi[7:0], valids[7:0]} !== {8'd7, 8'd8, 8'd1}) begin
      fails++;
      $display("FAIL after_reset_pulses: got clk=%0d latch=%0d valid=%0d required 7 8 1", rises, latch_hi, valids);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_poll_now_counter();
    test_poll_during_bit_hi();
    test_reset_mid_poll();
    tests++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL latch_clk_overlap: got %0d cycles required 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nes_pad_serial_reader.md
Name: nes_pad_serial_reader

Overview:
- Reads an original NES controller (CD4021 shift register) over its 3-wire latch/clock/data interface.
- Presents the buttons as an 8-bit active-high parallel vector to the NES core's controller input.
- The vector uses the core's button bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Down, 5 Up, 6 Right, 7 Left.
- Polls periodically or on demand, and pulses a valid strobe when a fresh vector is available.

Parameters:
- HALF_CYC, 300: clk cycles per pad_clk half-period (6 us at 50 MHz). Must be >= 4.
- LATCH_CYC, 600: clk cycles pad_latch is held high (12 us at 50 MHz). Must be >= 4.
- POLL_CYC, 833333: clk cycles between poll starts (~60 Hz at 50 MHz). Must be >= 1.

Ports:
- clk  in  1  system clock; the only clock domain.
- rst  in  1  synchronous, active-high reset.
- poll_now  in  1  single-cycle request to start a poll immediately.
- pad_data  in  1  serial data from the pad; asynchronous; low = pressed.
- pad_latch  out  1  parallel-load strobe to the pad; active high.
- pad_clk  out  1  shift clock to the pad; idle low.
- buttons  out  8  last complete vector; 1 = pressed; core bit order as in Overview.
- valid  out  1  one-cycle pulse when buttons is updated.
- busy  out  1  high while a poll is in progress (state != IDLE).

Behaviour:
- Reset values:
  - Outputs: pad_latch=0, pad_clk=0, buttons=8'h00, valid=0, busy=0.
  - Internal: state=IDLE, poll counter=0, bit index=0, shift register=0, both synchronizer flops=1 (released).
- Reset mid-poll: all outputs take their reset values on the next cycle. Any partial vector is discarded.
- pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted, so a pressed button reads as 1.
- Poll counter:
  - Cleared on the cycle the FSM enters LATCH; otherwise increments every cycle, saturating at POLL_CYC-1.
  - After reset, the first automatic poll begins after POLL_CYC idle cycles.
- FSM states and transitions:
  - IDLE: pad_latch=0, pad_clk=0. Go to LATCH when poll_now=1 or poll counter == POLL_CYC-1.
  - LATCH: pad_latch=1 for exactly LATCH_CYC cycles, then go to BIT_LO with index=0.
  - BIT_LO: pad_clk=0 for HALF_CYC cycles. On the last cycle, sample bit[index] into the shift register. If index==7 go to DONE, else go to BIT_HI.
  - BIT_HI: pad_clk=1 for HALF_CYC cycles, then index+1 and go to BIT_LO. The pad shifts on the pad_clk rising edge.
  - DONE: one cycle. buttons <= remapped vector, valid=1, then go to IDLE.
- Serial-to-output mapping (serial index 0..7 is the pad order A,B,Sel,Start,Up,Down,Left,Right):
  - s0->b0, s1->b1, s2->b2, s3->b3, s4->b5, s5->b4, s6->b7, s7->b6.
- Timing:
  - 7 pad_clk pulses per poll.
  - Poll duration, LATCH entry to DONE inclusive: LATCH_CYC + 15*HALF_CYC + 1 cycles.
  - valid fires on the DONE cycle; buttons shows the new value from the following cycle.
- Stability: buttons changes only on the cycle after DONE and holds its value between polls.
- poll_now while busy is ignored, not queued.
- poll_now coinciding with the counter expiring in IDLE starts a single poll.
- If POLL_CYC <= poll duration, polls run back-to-back with one IDLE cycle between them.
- pad_latch and pad_clk are never high in the same cycle. Both are registered outputs.

Test Plan (bench params HALF_CYC=4, LATCH_CYC=8, POLL_CYC=200; the pad model is a behavioural CD4021 driving pad_data low for pressed buttons):
- Reset, then idle -> outputs stay at reset values. First pad_latch rise occurs 200 cycles after rst deasserts. valid pulses 8+60+1=69 cycles after LATCH entry.
- Pad presses A only -> buttons=8'h01. Presses Up only -> 8'h20. Presses Left+Start -> 8'h88. Presses Right+Down+B -> 8'h52.
- All pressed -> 8'hFF. None pressed -> 8'h00. Exactly 7 pad_clk rising edges and 1 pad_latch pulse of 8 cycles per poll.
- poll_now pulsed in IDLE at counter=50 -> pad_latch rises next cycle. Poll counter restarts. Next automatic poll starts 200 cycles after that LATCH entry.
- poll_now pulsed during BIT_HI -> no extra poll. Only one valid pulse for the current poll.
- rst asserted during BIT_LO with index=3 -> next cycle: pad_clk=0, pad_latch=0, buttons=0, busy=0. After release, the first poll completes normally with a correct vector.
